// File: rtl/syn_fgyrus_fft_cache_hst_rdr.sv
// Purpose: FFT cache host-port master; on fft_done sweeps the host buffer, streams real samples, then optionally zero-clears it.
// Latency: fft_done -> first read 1 cycle; read -> out_valid P_BFFR_RDELAY+1 cycles; one bin per cycle when out_ready holds.
// Backpressure: reads issue only while outstanding + buffered < P_FIFO_DEPTH, so out_ready low stalls the sweep losslessly.
//
// Ports: clk_ir/rst_sync_l (sync active-low); fft_done start pulse; hst_* cache host port
// (addr, rd/wr strobes, wr data, rd valid/data); out_* valid/ready sample stream with bin index
// and frame-last flag; busy; sticky overrun with overrun_clr.

// Generic register FIFO: push_vld/pop_rdy handshake, synchronous active-low flush.
module syn_fgyrus_fft_cache_hst_rdr_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_ir,
    input  logic                       rst_sync_l,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [W-1:0]               pop_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign pop_vld = (count != '0);
    assign pop_dat = mem[rptr];
    assign do_push = push_vld && (count != CW'(DEPTH));
    assign do_pop  = pop_vld && pop_rdy;

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + 1'b1;
            if (do_pop)  rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; entries are only visible once pushed.
    always_ff @(posedge clk_ir) begin
        if (do_push) mem[wptr] <= push_dat;
    end
endmodule

module syn_fgyrus_fft_cache_hst_rdr #(
    parameter int P_BFFR_DATA_W = 32,
    parameter int P_BFFR_ADDR_W = 8,
    parameter int P_BFFR_RDELAY = 2,
    parameter int P_FIFO_DEPTH  = 4,
    parameter bit P_CLR_EN      = 1'b1
) (
    input  logic                     clk_ir,
    input  logic                     rst_sync_l,
    input  logic                     fft_done,
    output logic [P_BFFR_ADDR_W-1:0] hst_addr,
    output logic                     hst_rd_en,
    output logic                     hst_wr_en,
    output logic [P_BFFR_DATA_W-1:0] hst_wr_data,
    input  logic                     hst_rd_valid,
    input  logic [P_BFFR_DATA_W-1:0] hst_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [P_BFFR_DATA_W-1:0] out_data,
    output logic [P_BFFR_ADDR_W-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);
    localparam int CW = $clog2(P_FIFO_DEPTH+1);
    localparam logic [P_BFFR_ADDR_W-1:0] LAST_ADDR = {P_BFFR_ADDR_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_CLR} state_t;

    typedef struct packed {
        logic [P_BFFR_DATA_W-1:0] dat;
        logic [P_BFFR_ADDR_W-1:0] idx;
    } smp_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [P_BFFR_ADDR_W-1:0] rd_addr;
    logic [P_BFFR_ADDR_W-1:0] rtn_idx;
    logic [CW-1:0]            outstanding;
    logic [CW-1:0]            fifo_cnt;
    logic [CW-1:0]            out_nxt;
    logic [CW-1:0]            cnt_nxt;
    logic [CW:0]              occ_nxt;
    logic                     rtn_acc;
    logic                     fifo_pop;
    logic                     credit_ok;
    logic                     rd_issue;
    logic                     wr_nxt;
    logic [P_BFFR_ADDR_W-1:0] addr_nxt;
    smp_t                     push_smp;
    smp_t                     head_smp;

    // Returns with nothing in flight are stray and dropped.
    assign rtn_acc  = hst_rd_valid && (outstanding != '0);
    assign fifo_pop = out_valid && out_ready;

    // Occupancy as it will stand next cycle; the strobe currently on the bus counts as outstanding.
    assign out_nxt   = outstanding + CW'(hst_rd_en) - CW'(rtn_acc);
    assign cnt_nxt   = fifo_cnt + CW'(rtn_acc) - CW'(fifo_pop);
    assign occ_nxt   = {1'b0, out_nxt} + {1'b0, cnt_nxt};
    assign credit_ok = occ_nxt < (CW+1)'(P_FIFO_DEPTH);

    assign hst_wr_data = '0;

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // WAIT uses the look-ahead occupancy so the first clear write (or idle)
    // lands in the cycle the pipeline has fully drained.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (fft_done) state_nxt = S_RD;
            S_RD:   if (hst_rd_en && hst_addr == LAST_ADDR) state_nxt = S_WAIT;
            S_WAIT: if (out_nxt == '0 && cnt_nxt == '0) state_nxt = P_CLR_EN ? S_CLR : S_IDLE;
            S_CLR:  if (hst_wr_en && hst_addr == LAST_ADDR) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered host-port strobes and address.
    always_comb begin
        rd_issue = (state_nxt == S_RD) && credit_ok;
        wr_nxt   = (state_nxt == S_CLR);
        addr_nxt = hst_addr;
        if (rd_issue)                 addr_nxt = rd_addr;
        else if (wr_nxt)              addr_nxt = (state == S_CLR) ? hst_addr + 1'b1 : '0;
        else if (state_nxt == S_IDLE) addr_nxt = '0;
    end

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            hst_rd_en   <= 1'b0;
            hst_wr_en   <= 1'b0;
            hst_addr    <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            rd_addr     <= '0;
            rtn_idx     <= '0;
            outstanding <= '0;
        end else begin
            hst_rd_en   <= rd_issue;
            hst_wr_en   <= wr_nxt;
            hst_addr    <= addr_nxt;
            busy        <= (state_nxt != S_IDLE);
            outstanding <= out_nxt;
            if (state_nxt == S_IDLE) rd_addr <= '0;
            else if (rd_issue)       rd_addr <= rd_addr + 1'b1;
            if (state == S_IDLE)     rtn_idx <= '0;
            else if (rtn_acc)        rtn_idx <= rtn_idx + 1'b1;
            // Set takes priority over clear.
            if (fft_done && state != S_IDLE) overrun <= 1'b1;
            else if (overrun_clr)            overrun <= 1'b0;
        end
    end

    assign push_smp.dat = hst_rd_data;
    assign push_smp.idx = rtn_idx;

    syn_fgyrus_fft_cache_hst_rdr_fifo #(
        .W     ($bits(smp_t)),
        .DEPTH (P_FIFO_DEPTH)
    ) u_out_fifo (
        .clk_ir     (clk_ir),
        .rst_sync_l (rst_sync_l),
        .push_vld   (rtn_acc),
        .push_dat   (push_smp),
        .pop_vld    (out_valid),
        .pop_rdy    (out_ready),
        .pop_dat    (head_smp),
        .count      (fifo_cnt)
    );

    assign out_data = head_smp.dat;
    assign out_idx  = head_smp.idx;
    assign out_last = out_valid && (head_smp.idx == LAST_ADDR);
endmodule

// File: tb/tb_syn_fgyrus_fft_cache_hst_rdr.sv
// Bench for syn_fgyrus_fft_cache_hst_rdr: behavioural cache with 2-cycle read latency,
// scoreboard of expected {last, idx, data} beats filled at each fft_done.
// A second instance with clearing disabled checks the no-clear variant.
module tb_syn_fgyrus_fft_cache_hst_rdr;
    localparam int N = 256;

    logic clk_ir = 1'b0;
    always #5 clk_ir = ~clk_ir;

    logic        rst_sync_l, fft_done, out_ready, overrun_clr;
    logic [7:0]  hst_addr, out_idx;
    logic        hst_rd_en, hst_wr_en, hst_rd_valid, out_valid, out_last, busy, overrun;
    logic [31:0] hst_wr_data, hst_rd_data, out_data;

    logic        fft_done_nc, out_ready_nc, overrun_clr_nc;
    logic [7:0]  hst_addr_nc, out_idx_nc;
    logic        hst_rd_en_nc, hst_wr_en_nc, hst_rd_valid_nc, out_valid_nc, out_last_nc, busy_nc, overrun_nc;
    logic [31:0] hst_wr_data_nc, hst_rd_data_nc, out_data_nc;

    syn_fgyrus_fft_cache_hst_rdr #(.P_CLR_EN(1'b1)) u_dut (
        .clk_ir(clk_ir), .rst_sync_l(rst_sync_l), .fft_done(fft_done),
        .hst_addr(hst_addr), .hst_rd_en(hst_rd_en), .hst_wr_en(hst_wr_en), .hst_wr_data(hst_wr_data),
        .hst_rd_valid(hst_rd_valid), .hst_rd_data(hst_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr));

    syn_fgyrus_fft_cache_hst_rdr #(.P_CLR_EN(1'b0)) u_dut_nc (
        .clk_ir(clk_ir), .rst_sync_l(rst_sync_l), .fft_done(fft_done_nc),
        .hst_addr(hst_addr_nc), .hst_rd_en(hst_rd_en_nc), .hst_wr_en(hst_wr_en_nc), .hst_wr_data(hst_wr_data_nc),
        .hst_rd_valid(hst_rd_valid_nc), .hst_rd_data(hst_rd_data_nc),
        .out_valid(out_valid_nc), .out_ready(out_ready_nc), .out_data(out_data_nc), .out_idx(out_idx_nc),
        .out_last(out_last_nc), .busy(busy_nc), .overrun(overrun_nc), .overrun_clr(overrun_clr_nc));

    int cyc = 0;
    always @(posedge clk_ir) cyc <= cyc + 1;

    // Cache model: 2-cycle read pipeline, writes land immediately, preload fills 0x1000+idx.
    logic [31:0] mem [N];
    logic        preload;
    logic        p1_v;
    logic [31:0] p1_d;
    always @(posedge clk_ir) begin
        if (preload) for (int i = 0; i < N; i++) mem[i] <= 32'h1000 + 32'(i);
        if (hst_wr_en) mem[hst_addr] <= hst_wr_data;
        if (!rst_sync_l) begin
            p1_v <= 1'b0; p1_d <= '0; hst_rd_valid <= 1'b0; hst_rd_data <= '0;
        end else begin
            p1_v <= hst_rd_en; p1_d <= mem[hst_addr];
            hst_rd_valid <= p1_v; hst_rd_data <= p1_d;
        end
    end

    // Cache model for the no-clear instance: data is 0x2000+addr.
    logic        q1_v;
    logic [31:0] q1_d;
    always @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            q1_v <= 1'b0; q1_d <= '0; hst_rd_valid_nc <= 1'b0; hst_rd_data_nc <= '0;
        end else begin
            q1_v <= hst_rd_en_nc; q1_d <= 32'h2000 + {24'h0, hst_addr_nc};
            hst_rd_valid_nc <= q1_v; hst_rd_data_nc <= q1_d;
        end
    end

    int checks = 0, failures = 0;
    logic [40:0] sb [$];
    int start, rel;
    int rd_issued, pops, max_inflight, wr_cnt, first_rd, first_wr, first_ov, last_rel, last_cnt, busy_fall, both_hot, extra;
    int nc_wr, nc_beats, nc_busy_fall, nc_last_rel;
    logic [7:0] nc_next;
    bit rnd_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [40:0] e;
        rel = cyc - start;
        if (hst_rd_en && hst_wr_en) both_hot++;
        if (hst_rd_en) begin
            if (first_rd < 0) first_rd = rel;
            rd_issued++;
        end
        if (rd_issued - pops > max_inflight) max_inflight = rd_issued - pops;
        if (hst_wr_en) begin
            if (first_wr < 0) first_wr = rel;
            wr_cnt++;
        end
        if (out_valid && first_ov < 0) first_ov = rel;
        if (out_last) begin last_cnt++; last_rel = rel; end
        if (out_valid && out_ready) begin
            pops++;
            if (sb.size() == 0) extra++;
            else begin
                e = sb.pop_front();
                chk("beat", {23'h0, out_last, out_idx, out_data}, {23'h0, e});
            end
        end
        if (!busy && rel > 1 && busy_fall < 0) busy_fall = rel;
        if (hst_wr_en_nc) nc_wr++;
        if (out_valid_nc && out_ready_nc) begin
            chk("nc_beat", {24'h0, out_idx_nc, out_data_nc}, {24'h0, nc_next, 32'h2000 + {24'h0, nc_next}});
            nc_next++;
            nc_beats++;
        end
        if (out_last_nc) nc_last_rel = rel;
        if (!busy_nc && rel > 1 && nc_busy_fall < 0) nc_busy_fall = rel;
    endtask

    task automatic step();
        @(negedge clk_ir);
        mon();
        @(posedge clk_ir);
        #1;
        fft_done = 1'b0; fft_done_nc = 1'b0; overrun_clr = 1'b0;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        start = cyc;
        rd_issued = 0; pops = 0; max_inflight = 0; wr_cnt = 0; first_rd = -1; first_wr = -1;
        first_ov = -1; last_rel = -1; last_cnt = 0; busy_fall = -1; both_hot = 0; extra = 0;
        nc_beats = 0; nc_busy_fall = -1; nc_last_rel = -1; nc_next = 8'h0;
    endtask

    // Called just after a rising edge: the pulse is sampled at the end of cycle 0.
    task automatic start_sweep(input bit preloaded);
        clear_mon();
        fft_done = 1'b1;
        for (int i = 0; i < N; i++)
            sb.push_back({(i == N-1), 8'(i), preloaded ? 32'h1000 + 32'(i) : 32'h0});
    endtask

    task automatic do_preload();
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        do begin step(); n++; end while ((busy || n < 3) && n < 3000);
        step();
        chk({tag, "_done"}, 64'(n < 3000), 64'h1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'h0);
        chk({tag, "_extra"}, 64'(extra), 64'h0);
        chk({tag, "_inflight_le4"}, 64'(max_inflight <= 4), 64'h1);
        chk({tag, "_rd_wr_excl"}, 64'(both_hot), 64'h0);
    endtask

    initial begin
        rst_sync_l = 1'b0; fft_done = 1'b0; out_ready = 1'b1; overrun_clr = 1'b0; preload = 1'b0;
        fft_done_nc = 1'b0; out_ready_nc = 1'b1; overrun_clr_nc = 1'b0; rnd_rdy = 1'b0;
        nc_wr = 0;
        clear_mon();
        repeat (3) step();

        // Reset state
        @(negedge clk_ir);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_rd_en", 64'(hst_rd_en), 64'h0);
        chk("rst_wr_en", 64'(hst_wr_en), 64'h0);
        chk("rst_addr", 64'(hst_addr), 64'h0);
        chk("rst_wr_data", 64'(hst_wr_data), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_overrun", 64'(overrun), 64'h0);
        @(posedge clk_ir); #1;
        rst_sync_l = 1'b1;
        step();

        // Full-rate sweep with clear
        do_preload();
        start_sweep(1'b1);
        run_until_idle("full");
        chk("full_first_rd", 64'(first_rd), 64'd1);
        chk("full_first_ov", 64'(first_ov), 64'd4);
        chk("full_last_cyc", 64'(last_rel), 64'd259);
        chk("full_last_cnt", 64'(last_cnt), 64'd1);
        chk("full_first_wr", 64'(first_wr), 64'd260);
        chk("full_wr_cnt", 64'(wr_cnt), 64'd256);
        chk("full_busy_fall", 64'(busy_fall), 64'd516);

        // Random back-pressure
        do_preload();
        rnd_rdy = 1'b1;
        start_sweep(1'b1);
        run_until_idle("rand");
        chk("rand_rd_cnt", 64'(rd_issued), 64'd256);
        rnd_rdy = 1'b0;
        out_ready = 1'b1;

        // Buffer cleared by the previous sweep reads back as zeros
        start_sweep(1'b0);
        run_until_idle("zero");

        // Stall: out_ready low for 20 cycles
        do_preload();
        out_ready = 1'b0;
        start_sweep(1'b1);
        repeat (20) step();
        chk("stall_rd_cnt", 64'(rd_issued), 64'd4);
        chk("stall_rd_en", 64'(hst_rd_en), 64'h0);
        chk("stall_head_idx", {55'h0, out_valid, out_idx}, {55'h0, 1'b1, 8'd0});
        out_ready = 1'b1;
        run_until_idle("stall");

        // Overrun: second fft_done mid-sweep
        start_sweep(1'b0);
        while (cyc - start < 100) step();
        fft_done = 1'b1;
        step();
        chk("ovr_set", 64'(overrun), 64'h1);
        run_until_idle("ovr");
        repeat (10) step();
        chk("ovr_no_second", {62'h0, busy, hst_rd_en}, 64'h0);
        chk("ovr_rd_cnt", 64'(rd_issued), 64'd256);
        chk("ovr_sticky", 64'(overrun), 64'h1);
        overrun_clr = 1'b1;
        step();
        chk("ovr_clr", 64'(overrun), 64'h0);

        // Reset in cycle 50 of a sweep
        start_sweep(1'b0);
        while (cyc - start < 50) step();
        rst_sync_l = 1'b0;
        step();
        chk("mrst_state", {60'h0, busy, out_valid, hst_rd_en, hst_wr_en}, 64'h0);
        sb.delete();
        rst_sync_l = 1'b1;
        repeat (2) step();
        start_sweep(1'b0);
        run_until_idle("post_rst");
        chk("post_rst_first_ov", 64'(first_ov), 64'd4);

        // Clearing disabled
        clear_mon();
        fft_done_nc = 1'b1;
        begin
            int n = 0;
            do begin step(); n++; end while ((busy_nc || n < 3) && n < 3000);
            step();
            chk("nc_done", 64'(n < 3000), 64'h1);
        end
        chk("nc_beats", 64'(nc_beats), 64'd256);
        chk("nc_last_cyc", 64'(nc_last_rel), 64'd259);
        chk("nc_busy_fall", 64'(nc_busy_fall), 64'd260);
        chk("nc_no_wr", 64'(nc_wr), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
